// File: rtl/flight_pkg.sv
// Shared state encoding, control payload and defaults for the flight sequencer.
package flight_pkg;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_ARMED  = 3'd1,
    ST_BOOST  = 3'd2,
    ST_GIMBAL = 3'd3,
    ST_COAST  = 3'd4,
    ST_DONE   = 3'd5,
    ST_SAFE   = 3'd6
  } state_e;

  localparam int unsigned     PHASE_W            = 3;
  localparam longint unsigned GIMBAL_ALT_DEFAULT = 64'd30_000_000_000_000;

  typedef struct packed {
    logic launch_ack;
    logic start_integration;
    logic engine_on;
    logic gimbal_enable;
    logic done;
  } ctrl_t;

  // States in which the flight clock advances and the integrator is live.
  function automatic logic timer_runs(input state_e s);
    return (s == ST_BOOST) || (s == ST_GIMBAL) || (s == ST_COAST);
  endfunction

endpackage

// File: rtl/sec_timer.sv
// Prescaler plus saturating seconds counter; exposes the next-seconds value so
// the sequencer can act on the same edge the count advances.
module sec_timer #(
  parameter int unsigned N             = 64,
  parameter int unsigned TICKS_PER_SEC = 50_000_000
) (
  input  logic         CLK,
  input  logic         RESETB,
  input  logic         run,
  input  logic         clear,
  output logic         tick,
  output logic [N-1:0] seconds,
  output logic         wrap_c,
  output logic [N-1:0] seconds_nxt_c
);

  localparam int unsigned     PW   = (TICKS_PER_SEC > 1) ? $clog2(TICKS_PER_SEC) : 1;
  localparam logic [PW-1:0]   LAST = PW'(TICKS_PER_SEC - 1);

  logic [PW-1:0] presc_q;

  assign wrap_c        = run && (presc_q == LAST);
  assign seconds_nxt_c = (wrap_c && (seconds != '1)) ? seconds + N'(1) : seconds;

  always_ff @(posedge CLK or negedge RESETB) begin
    if (!RESETB) begin
      presc_q <= '0;
      seconds <= '0;
      tick    <= 1'b0;
    end else if (clear) begin
      presc_q <= '0;
      seconds <= '0;
      tick    <= 1'b0;
    end else begin
      tick    <= wrap_c;
      seconds <= seconds_nxt_c;
      if (run) presc_q <= wrap_c ? '0 : presc_q + PW'(1);
    end
  end

endmodule

// File: rtl/flight_sequencer.sv
// Launch-to-landing flight phase sequencer: arms on launch, times the burn,
// enables the gimbal at altitude and finishes on descent; abort drops to SAFE.
module flight_sequencer
  import flight_pkg::*;
#(
  parameter int unsigned     N             = 64,
  parameter int unsigned     TICKS_PER_SEC = 50_000_000,
  parameter longint unsigned GIMBAL_ALT    = GIMBAL_ALT_DEFAULT
) (
  input  logic               CLK,
  input  logic               RESETB,
  input  logic               launch,
  input  logic               abort,
  input  logic [N-1:0]       burntime,
  input  logic [N-1:0]       height,
  input  logic [N-1:0]       velocity,
  output logic               launch_ack,
  output logic               start_integration,
  output logic               engine_on,
  output logic               gimbal_enable,
  output logic [PHASE_W-1:0] phase,
  output logic [N-1:0]       elapsed_s,
  output logic               tick_1s,
  output logic               done
);

  state_e       state_q, state_d;
  logic [N-1:0] burn_q, burn_d;
  ctrl_t        ctrl_q, ctrl_d;
  logic         gimbal_d;

  logic         accept_c, alt_c, desc_c, burnout_c, abortable_c;
  logic         wrap_c;
  logic [N-1:0] seconds_nxt_c;

  sec_timer #(
    .N             (N),
    .TICKS_PER_SEC (TICKS_PER_SEC)
  ) u_sec_timer (
    .CLK           (CLK),
    .RESETB        (RESETB),
    .run           (timer_runs(state_q)),
    .clear         (accept_c),
    .tick          (tick_1s),
    .seconds       (elapsed_s),
    .wrap_c        (wrap_c),
    .seconds_nxt_c (seconds_nxt_c)
  );

  assign accept_c    = (state_q == ST_IDLE) && launch;
  assign alt_c       = height >= N'(GIMBAL_ALT);
  assign desc_c      = $signed(velocity) < 0;
  // Burnout is judged only as the count advances, so burn_s=0 still waits one second.
  assign burnout_c   = wrap_c && (seconds_nxt_c >= burn_q);
  assign abortable_c = (state_q == ST_ARMED) || timer_runs(state_q);

  always_comb begin
    state_d  = state_q;
    burn_d   = burn_q;
    gimbal_d = ctrl_q.gimbal_enable;
    ctrl_d   = '0;

    case (state_q)
      ST_IDLE: begin
        if (launch) begin
          state_d = ST_ARMED;
          burn_d  = burntime;
        end
      end
      ST_ARMED: state_d = ST_BOOST;
      ST_BOOST: begin
        if (burnout_c) begin
          state_d  = ST_COAST;
          gimbal_d = alt_c;
        end else if (alt_c) begin
          state_d  = ST_GIMBAL;
          gimbal_d = 1'b1;
        end
      end
      ST_GIMBAL: begin
        if (burnout_c) state_d = ST_COAST;
      end
      ST_COAST: begin
        if (alt_c)  gimbal_d = 1'b1;
        if (desc_c) state_d  = ST_DONE;
      end
      ST_DONE: state_d = ST_DONE;
      ST_SAFE: begin
        if (!abort && !launch) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase

    if (abort && abortable_c) state_d = ST_SAFE;
    if ((state_d == ST_SAFE) || (state_d == ST_IDLE)) gimbal_d = 1'b0;

    ctrl_d.launch_ack        = accept_c;
    ctrl_d.engine_on         = (state_d == ST_BOOST) || (state_d == ST_GIMBAL);
    ctrl_d.start_integration = timer_runs(state_d);
    ctrl_d.gimbal_enable     = gimbal_d;
    ctrl_d.done              = ctrl_q.done || (state_d == ST_DONE);
  end

  always_ff @(posedge CLK or negedge RESETB) begin
    if (!RESETB) begin
      state_q <= ST_IDLE;
      burn_q  <= '0;
      ctrl_q  <= '0;
    end else begin
      state_q <= state_d;
      burn_q  <= burn_d;
      ctrl_q  <= ctrl_d;
    end
  end

  assign phase             = state_q;
  assign launch_ack        = ctrl_q.launch_ack;
  assign start_integration = ctrl_q.start_integration;
  assign engine_on         = ctrl_q.engine_on;
  assign gimbal_enable     = ctrl_q.gimbal_enable;
  assign done              = ctrl_q.done;

endmodule

// File: doc/flight_sequencer.md
FLIGHT_SEQUENCER -- requirements
Module: flight_sequencer

Interface
REQ-001 SHALL have parameter N, default 64, datapath word width.
REQ-002 SHALL have parameter TICKS_PER_SEC, default 50_000_000, CLK cycles per simulated second (>=2).
REQ-003 SHALL have parameter GIMBAL_ALT, default 30_000_000_000_000, gimbal-start height in 1e-12 km units (30 km).
REQ-004 SHALL have port CLK, input, 1, clock.
REQ-005 SHALL have port RESETB, input, 1, asynchronous active-low reset.
REQ-006 SHALL have port launch, input, 1, launch request, level, sampled in IDLE only.
REQ-007 SHALL have port abort, input, 1, abort request, level.
REQ-008 SHALL have port burntime, input, N, engine burn duration in whole seconds.
REQ-009 SHALL have port height, input, N, unsigned current height, same units as GIMBAL_ALT.
REQ-010 SHALL have port velocity, input, N, signed two's-complement vertical velocity.
REQ-011 SHALL have port launch_ack, output, 1, one-cycle pulse on launch acceptance.
REQ-012 SHALL have port start_integration, output, 1, enables height integrator.
REQ-013 SHALL have port engine_on, output, 1, thrust active.
REQ-014 SHALL have port gimbal_enable, output, 1, gimbal/altitude-calculator active.
REQ-015 SHALL have port phase, output, 3, current state encoding.
REQ-016 SHALL have port elapsed_s, output, N, seconds since launch acceptance.
REQ-017 SHALL have port tick_1s, output, 1, one-cycle pulse at each elapsed_s increment.
REQ-018 SHALL have port done, output, 1, sticky flight-finished flag.

Function
REQ-019 SHALL implement states IDLE=0, ARMED=1, BOOST=2, GIMBAL=3, COAST=4, DONE=5, SAFE=6; phase = state code.
REQ-020 IDLE: launch=1 -> ARMED next cycle; burntime latched into internal burn_s; launch_ack pulses that same edge; elapsed_s and prescaler cleared.
REQ-021 ARMED: unconditional -> BOOST after exactly one cycle; start_integration, engine_on rise entering BOOST.
REQ-022 Prescaler: counts 0..TICKS_PER_SEC-1 in BOOST, GIMBAL, COAST only; on wrap, elapsed_s +1 and tick_1s pulses same cycle; frozen in other states.
REQ-023 BOOST: height >= GIMBAL_ALT -> GIMBAL; gimbal_enable rises on entry, remains 1 through COAST and DONE.
REQ-024 BOOST/GIMBAL: elapsed_s >= burn_s (compared after increment) -> COAST; engine_on falls on entry.
REQ-025 Simultaneous altitude and burnout in BOOST: -> COAST with gimbal_enable=1 set same edge.
REQ-026 COAST: velocity sign bit =1 (descending) -> DONE; if height >= GIMBAL_ALT while gimbal_enable=0, set gimbal_enable.
REQ-027 DONE: start_integration=0, done=1, elapsed_s frozen; only reset exits.
REQ-028 abort=1 in ARMED, BOOST, GIMBAL, COAST -> SAFE next edge, overriding all other transitions; ignored in IDLE, DONE.
REQ-029 SAFE: engine_on, start_integration, gimbal_enable = 0; elapsed_s frozen; abort=0 and launch=0 -> IDLE.
REQ-030 burn_s=0: BOOST -> COAST at first tick_1s.
REQ-031 elapsed_s saturates at all-ones, no wrap.
REQ-032 All outputs registered; no combinational input-to-output path.

Reset
REQ-033 RESETB=0 SHALL force state IDLE, all outputs 0, elapsed_s 0, prescaler 0, burn_s 0, asynchronously, including mid-flight.
REQ-034 After RESETB release, first launch sample SHALL occur on the first CLK edge.

Structure
REQ-035 State codes and default GIMBAL_ALT SHALL reside in shared package flight_pkg.
REQ-036 Prescaler+seconds counter SHALL be sub-module sec_timer (inputs run, clear; outputs tick, seconds).

Verification
REQ-037 TICKS_PER_SEC=4, burntime=3, launch pulse, height=0 -> launch_ack 1 cycle, phase 1 then 2, COAST entered at elapsed_s=3 (12 CLKs after BOOST entry), engine_on 0.
REQ-038 In BOOST, drive height=GIMBAL_ALT at elapsed_s=1 -> phase 3, gimbal_enable=1 next edge, engine_on stays 1 until elapsed_s=3.
REQ-039 In COAST, velocity=-1 -> phase 5, done=1, start_integration=0, elapsed_s frozen for 20 cycles.
REQ-040 abort=1 in GIMBAL -> phase 6 next edge, all enables 0; abort=0, launch=0 -> phase 0.
REQ-041 Height reaches GIMBAL_ALT on same edge elapsed_s reaches burn_s -> phase 4, gimbal_enable=1.
REQ-042 RESETB=0 mid-BOOST -> all outputs 0 immediately, phase 0; burntime=0 relaunch -> COAST at first tick_1s.
